// File: rtl/fifo_shift_ram_pkg.sv
// Shared constants and types for the shift-RAM read side: level address
// windows, per-level depth helper and the output buffer entry type.
package fifo_shift_ram_pkg;
  localparam int NUM_LEVELS = 11;
  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 8;
  localparam int LVL_W      = 4;
  localparam int CNT_W      = 8;

  localparam int G_MIN [NUM_LEVELS] = '{0, 64, 128, 256, 384, 512, 640, 768, 1024, 1280, 1536};
  localparam int G_MAX [NUM_LEVELS] = '{16, 97, 178, 323, 468, 613, 758, 903, 1176, 1449, 1722};

  function automatic int level_depth(input int i);
    return G_MAX[i] - G_MIN[i] + 1;
  endfunction

  typedef struct packed {
    logic [LVL_W-1:0]  level;
    logic [DATA_W-1:0] data;
  } rd_entry_t;
endpackage

// File: rtl/fifo_shift_ram_rd_obuf.sv
// Output FIFO of {level, data} words returned from RAM port B.
// Occupancy is exported so the reader can reserve space before issuing reads.
module fifo_shift_ram_rd_obuf
  import fifo_shift_ram_pkg::*;
#(
  parameter int BUF_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  rd_entry_t                      din,
  input  logic                           pop,
  output rd_entry_t                      dout,
  output logic                           out_valid,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_cnt
);
  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int BCNT_W = $clog2(BUF_DEPTH+1);

  rd_entry_t        mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (buf_cnt != '0);
  assign do_pop    = pop && out_valid;
  assign dout      = mem[rd_ptr];

  // Storage, pointers and occupancy; contents cleared so outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      buf_cnt <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      buf_cnt <= buf_cnt + BCNT_W'(wr_en) - BCNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/fifo_shift_ram_reader.sv
// Read-side controller for the 11-level shift RAM: per-level occupancy and
// wrapping read pointers, RAM port B issue, and a valid/ready output buffer.
// Optional assertions: define FIFO_SHIFT_RAM_READER_CHECK_EN.
module fifo_shift_ram_reader #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int NUM_LEVELS = 11,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ram_we,
  input  logic [NUM_LEVELS-1:0] push,
  input  logic                  rd_req,
  input  logic [3:0]            rd_sel,
  output logic                  rd_ack,
  output logic                  ram_re,
  output logic [ADDR_W-1:0]     addrb,
  input  logic [DATA_W-1:0]     ram_doutb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [3:0]            out_level,
  output logic [NUM_LEVELS-1:0] empty,
  output logic [NUM_LEVELS-1:0] err_ovf,
  output logic                  err_sel
);
  import fifo_shift_ram_pkg::*;

  localparam int BCNT_W = $clog2(BUF_DEPTH+1);
  localparam int OCC_W  = BCNT_W + 1;

  logic [ADDR_W-1:0]     rptr [NUM_LEVELS];
  logic [CNT_W-1:0]      cnt  [NUM_LEVELS];
  logic [NUM_LEVELS-1:0] lvl_wr, lvl_rd;
  // vld_pipe[1]: read issued to RAM, vld_pipe[2]: RAM data on ram_doutb
  logic [2:1]            vld_pipe;
  logic [3:0]            lvl_s1, lvl_s2;
  logic [BCNT_W-1:0]     buf_cnt;
  logic [1:0]            inflight;
  logic [OCC_W-1:0]      occ;
  logic                  sel_ok, sel_nz;
  logic [ADDR_W-1:0]     sel_ptr;
  rd_entry_t             ob_din, ob_dout;

  // Accept decision: valid level, data present, and room reserved in the buffer.
  always_comb begin
    sel_nz  = 1'b0;
    sel_ptr = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (rd_sel == 4'(i)) begin
        sel_nz  = (cnt[i] != '0);
        sel_ptr = rptr[i];
      end
    end
    sel_ok   = (rd_sel < 4'(NUM_LEVELS));
    inflight = {1'b0, vld_pipe[1]} + {1'b0, vld_pipe[2]};
    occ      = OCC_W'(buf_cnt) + OCC_W'(inflight);
    rd_ack   = !reset && rd_req && sel_ok && sel_nz && (occ < OCC_W'(BUF_DEPTH));
    err_sel  = !reset && rd_req && !sel_ok;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      lvl_wr[i] = ram_we && push[i];
      lvl_rd[i] = rd_ack && (rd_sel == 4'(i));
      empty[i]  = (cnt[i] == '0);
    end
  end

  // Per-level occupancy, read pointer wrap and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_ovf <= '0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
        cnt[i]  <= '0;
        rptr[i] <= ADDR_W'(G_MIN[i]);
      end
    end else begin
      for (int i = 0; i < NUM_LEVELS; i++) begin
        if (lvl_rd[i])
          rptr[i] <= (rptr[i] == ADDR_W'(G_MAX[i])) ? ADDR_W'(G_MIN[i]) : rptr[i] + 1'b1;
        if (lvl_wr[i] && !lvl_rd[i]) begin
          if (cnt[i] == CNT_W'(level_depth(i))) err_ovf[i] <= 1'b1;
          else                                  cnt[i]     <= cnt[i] + 1'b1;
        end else if (lvl_rd[i] && !lvl_wr[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  // Read issue pipeline; clearing vld_pipe drops any word still returning after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      addrb    <= '0;
      lvl_s1   <= '0;
      lvl_s2   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], rd_ack};
      if (rd_ack) begin
        addrb  <= sel_ptr;
        lvl_s1 <= rd_sel;
      end
      lvl_s2 <= lvl_s1;
    end
  end

  assign ram_re = vld_pipe[1];
  assign ob_din = '{level: lvl_s2, data: ram_doutb};

  fifo_shift_ram_rd_obuf #(.BUF_DEPTH(BUF_DEPTH)) u_obuf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (vld_pipe[2]),
    .din       (ob_din),
    .pop       (out_ready),
    .dout      (ob_dout),
    .out_valid (out_valid),
    .buf_cnt   (buf_cnt)
  );

  assign out_data  = ob_dout.data;
  assign out_level = ob_dout.level;

`ifdef FIFO_SHIFT_RAM_READER_CHECK_EN
  function automatic logic in_win(input logic [3:0] l, input logic [ADDR_W-1:0] a);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_LEVELS; i++)
      if (l == 4'(i)) r = (int'(a) >= G_MIN[i]) && (int'(a) <= G_MAX[i]);
    return r;
  endfunction

  a_addr_win: assert property (@(posedge clk) disable iff (reset) ram_re |-> in_win(lvl_s1, addrb));
  a_push_1h:  assert property (@(posedge clk) disable iff (reset) ram_we |-> $onehot(push));
  a_buf_occ:  assert property (@(posedge clk) disable iff (reset) int'(buf_cnt) <= BUF_DEPTH);
  for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_cnt_chk
    a_cnt_max: assert property (@(posedge clk) disable iff (reset) cnt[g] <= CNT_W'(level_depth(g)));
  end
`endif
endmodule

// File: tb/tb_fifo_shift_ram_reader.sv
// Scoreboard bench for fifo_shift_ram_reader with a behavioural RAM on port B.
module tb_fifo_shift_ram_reader;
  import fifo_shift_ram_pkg::*;

  logic        clk = 0, reset = 1, ram_we = 0, rd_req = 0, out_ready = 0;
  logic [10:0] push = '0;
  logic [3:0]  rd_sel = '0;
  logic        rd_ack, ram_re, out_valid, err_sel;
  logic [10:0] addrb, empty, err_ovf;
  logic [7:0]  ram_doutb = '0, out_data;
  logic [3:0]  out_level;

  always #5 clk = ~clk;

  fifo_shift_ram_reader dut (
    .clk(clk), .reset(reset), .ram_we(ram_we), .push(push), .rd_req(rd_req),
    .rd_sel(rd_sel), .rd_ack(rd_ack), .ram_re(ram_re), .addrb(addrb),
    .ram_doutb(ram_doutb), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_level(out_level), .empty(empty),
    .err_ovf(err_ovf), .err_sel(err_sel)
  );

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
    logic [3:0]  lvl;
  } ent_t;

  ent_t        lvlq [NUM_LEVELS][$];  // words written but not yet accepted, per level
  ent_t        sb[$];                 // accepted words awaiting output
  logic [10:0] aq[$];                 // accepted addresses awaiting ram_re
  int          wptr [NUM_LEVELS];
  logic [7:0]  mem [2048];
  logic        tb_we = 0;
  logic [10:0] addra = '0;
  logic [7:0]  wdata = '0;
  int          vectors = 0, miscompares = 0, n_ack = 0, n_pop = 0, cyc = 0;
  ent_t        me;

  // Behavioural RAM: write port A from the bench, 1-cycle read on port B.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_we) mem[addra] <= wdata;
    if (ram_re) ram_doutb <= mem[addrb];
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Monitor: accepts feed the scoreboard, issues and pops are checked against it.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_ack) begin
        n_ack++;
        if (rd_sel < 4'd11) begin
          if (lvlq[rd_sel].size() > 0) begin
            me = lvlq[rd_sel].pop_front();
            aq.push_back(me.addr);
            sb.push_back(me);
          end else chk("spurious_ack", 1, 0);
        end else chk("ack_bad_sel", 1, 0);
      end
      if (ram_re) begin
        if (aq.size() > 0) chk("addrb", addrb, aq.pop_front());
        else               chk("spurious_re", 1, 0);
      end
      if (out_valid && out_ready) begin
        n_pop++;
        if (sb.size() > 0) begin
          me = sb.pop_front();
          chk("out_data", out_data, me.data);
          chk("out_level", out_level, me.lvl);
        end else chk("spurious_pop", 1, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; rd_req = 0; ram_we = 0; push = '0; tb_we = 0;
    tick(); tick();
    reset = 0;
    sb.delete(); aq.delete();
    for (int i = 0; i < NUM_LEVELS; i++) begin
      lvlq[i].delete();
      wptr[i] = G_MIN[i];
    end
  endtask

  // Drive one write-side cycle for a level (no clock advance).
  task automatic wr_drive(int lvl);
    ram_we = 1;
    push   = 11'(1) << lvl;
    if (lvlq[lvl].size() < level_depth(lvl)) begin
      tb_we = 1;
      addra = 11'(wptr[lvl]);
      wdata = 8'($urandom);
      lvlq[lvl].push_back('{addr: addra, data: wdata, lvl: 4'(lvl)});
      wptr[lvl] = (wptr[lvl] == G_MAX[lvl]) ? G_MIN[lvl] : wptr[lvl] + 1;
    end else tb_we = 0;
  endtask

  task automatic wr(int lvl, int n);
    for (int k = 0; k < n; k++) begin
      wr_drive(lvl);
      tick();
    end
    ram_we = 0; push = '0; tb_we = 0;
  endtask

  task automatic rd(int lvl, int ncyc);
    rd_req = 1; rd_sel = 4'(lvl);
    repeat (ncyc) tick();
    rd_req = 0;
  endtask

  task automatic drain(string tag);
    int k;
    out_ready = 1;
    for (k = 0; k < 50 && (sb.size() > 0 || aq.size() > 0); k++) tick();
    chk(tag, sb.size() + aq.size(), 0);
  endtask

  initial begin
    int a0, p0, t0;
    logic found, anyv;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, p0, t0;
    logic found, anyv;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_ram_re", ram_re, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_level", out_level, 0);
    chk("rst_empty", empty, 11'h7ff);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_err_sel", err_sel, 0);
    chk("rst_rd_ack", rd_ack, 0);
    tick();

    // Basic read of level 1 with latency check
    wr(1, 3);
    out_ready = 1;
    a0 = n_ack;
    rd_req = 1; rd_sel = 4'd1;
    found = 0; t0 = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (rd_ack) begin found = 1; t0 = cyc; end
    end
    chk("basic_first_ack", found, 1);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    chk("basic_valid_seen", found, 1);
    chk("basic_latency", cyc - t0, 3);
    tick();
    repeat (3) tick();
    rd_req = 0;
    drain("basic_drain");
    chk("basic_acks", n_ack - a0, 3);

    // Wrap-around on level 0: 16 reads leave rptr at 16, then 16 -> 0
    wr(0, 16);
    a0 = n_ack;
    rd(0, 22);
    drain("wrap_drain1");
    chk("wrap_acks1", n_ack - a0, 16);
    wr(0, 2);
    a0 = n_ack;
    rd(0, 6);
    drain("wrap_drain2");
    chk("wrap_acks2", n_ack - a0, 2);

    // Backpressure on level 3
    wr(3, 10);
    out_ready = 0;
    a0 = n_ack;
    rd_req = 1; rd_sel = 4'd3;
    repeat (12) tick();
    chk("bp_acks_held", n_ack - a0, 4);
    @(negedge clk);
    chk("bp_ack_low", rd_ack, 0);
    tick();
    p0 = n_pop;
    out_ready = 1;
    repeat (10) tick();
    chk("bp_pops_rate", n_pop - p0, 10);
    rd_req = 0;
    drain("bp_drain");
    chk("bp_acks_total", n_ack - a0, 10);

    // Simultaneous write and accept on level 2 with one word present
    wr(2, 1);
    a0 = n_ack;
    wr_drive(2);
    rd_req = 1; rd_sel = 4'd2;
    tick();
    ram_we = 0; push = '0; tb_we = 0; rd_req = 0;
    chk("sim_ack", n_ack - a0, 1);
    @(negedge clk);
    chk("sim_not_empty", empty[2], 0);
    tick();
    a0 = n_ack;
    rd(2, 6);
    drain("sim_drain");
    chk("sim_cnt_one", n_ack - a0, 1);
    chk("sim_empty_after", empty[2], 1);

    // Overflow on level 0 (depth 17)
    do_reset();
    wr(0, 17);
    @(negedge clk);
    chk("ovf_pre", err_ovf, 0);
    tick();
    wr(0, 1);
    @(negedge clk);
    chk("ovf_set", err_ovf, 11'h001);
    tick();
    repeat (3) tick();
    chk("ovf_sticky", err_ovf, 11'h001);
    a0 = n_ack;
    out_ready = 1;
    rd(0, 25);
    drain("ovf_drain");
    chk("ovf_cnt17", n_ack - a0, 17);
    chk("ovf_empty", empty[0], 1);
    chk("ovf_still_set", err_ovf, 11'h001);

    // Bad select: 12 and boundary 11
    rd_req = 1; rd_sel = 4'd12;
    @(negedge clk);
    chk("esel12_pulse", err_sel, 1);
    chk("esel12_noack", rd_ack, 0);
    tick();
    rd_sel = 4'd11;
    @(negedge clk);
    chk("esel11_pulse", err_sel, 1);
    tick();
    rd_req = 0;
    @(negedge clk);
    chk("esel_clear", err_sel, 0);
    tick();

    // Reset with two reads in flight
    wr(4, 4);
    out_ready = 0;
    a0 = n_ack;
    rd(4, 2);
    chk("rst_mid_acks", n_ack - a0, 2);
    do_reset();
    anyv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      anyv = anyv | out_valid;
    end
    chk("rst_mid_no_valid", anyv, 0);
    chk("rst_mid_empty", empty, 11'h7ff);
    chk("rst_mid_err_ovf", err_ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
